// File: rtl/vga_window_ctrl_if.sv
// ---------------------------------------------------------------------------
// vga_window_ctrl_if
// Image-memory read port between the VGA window controller and the memory
// holding the source image. The memory is synchronous: pix_data is valid one
// clock after the clock in which mem_rd/mem_addr are presented.
//
// Signals:
//   mem_rd    - read strobe, high for every visible pixel inside the window
//   mem_addr  - image address (row-major, IMG_W pixels per row)
//   pix_data  - {B,G,R}, CW bits per channel, R in the LSBs
//
// Modports:
//   master - the controller (drives mem_rd/mem_addr, receives pix_data)
//   slave  - the memory (receives mem_rd/mem_addr, drives pix_data)
// ---------------------------------------------------------------------------
interface vga_window_ctrl_if #(
  parameter int ADDR_W = 15,
  parameter int CW     = 2
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [3*CW-1:0]   pix_data;

  modport master (
    output mem_rd,
    output mem_addr,
    input  pix_data
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output pix_data
  );
endinterface

// File: rtl/vga_window_ctrl.sv
// ---------------------------------------------------------------------------
// vga_window_ctrl
// VGA timing generator that places an IMG_W x IMG_H image, optionally
// magnified 2x or 4x, at a programmable position inside the active area.
// Window position/scale are shadowed at the end of every frame so that
// changes never tear the frame being displayed.
//
// Pipeline (every output has the same 3-clock latency from the counters):
//   N   : hcnt/vcnt, window decode
//   N+1 : mem_rd/mem_addr registered
//   N+2 : memory returns pix_data
//   N+3 : vga_rgb, vga_hsync, vga_vsync, frame_start registered
//
// Ports:
//   clk25M      - pixel clock
//   reset_n     - asynchronous active-low reset
//   win_x/win_y - window top-left corner (column/line)
//   win_scale   - 0=1x, 1=2x, 2=4x, 3=1x
//   mem         - image-memory read port (vga_window_ctrl_if.master)
//   vga_hsync   - horizontal sync, asserted level SYNC_POL
//   vga_vsync   - vertical sync, asserted level SYNC_POL
//   vga_rgb     - {R[3:0],G[3:0],B[3:0]}
//   frame_start - one-clock pulse coincident with output pixel (0,0)
//
// Build option:
//   VGA_BORDER_EN - when defined, a 2-pixel frame around the active area is
//                   painted BORDER_COLOR on top of image and background.
// ---------------------------------------------------------------------------
module vga_window_ctrl #(
  parameter int          H_ACTIVE     = 640,
  parameter int          H_FP         = 16,
  parameter int          H_SYNC       = 96,
  parameter int          H_BP         = 48,
  parameter int          V_ACTIVE     = 480,
  parameter int          V_FP         = 10,
  parameter int          V_SYNC       = 2,
  parameter int          V_BP         = 33,
  parameter int          IMG_W        = 256,
  parameter int          IMG_H        = 128,
  parameter int          ADDR_W       = 15,
  parameter int          CW           = 2,
  parameter bit          SYNC_POL     = 1'b0,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] BORDER_COLOR = 12'hF00
) (
  input  logic                     clk25M,
  input  logic                     reset_n,
  input  logic [9:0]               win_x,
  input  logic [9:0]               win_y,
  input  logic [1:0]               win_scale,
  vga_window_ctrl_if.master        mem,
  output logic                     vga_hsync,
  output logic                     vga_vsync,
  output logic [11:0]              vga_rgb,
  output logic                     frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HCW     = $clog2(H_TOTAL);
  localparam int VCW     = $clog2(V_TOTAL);

  // Replicate a CW-bit channel MSB-first into 4 bits: the top 4 bits of
  // four back-to-back copies give e.g. ab -> abab, abc -> abca.
  function automatic logic [3:0] expand_chan(input logic [CW-1:0] ch);
    logic [4*CW-1:0] rep;
    rep = {4{ch}};
    return rep[4*CW-1 -: 4];
  endfunction

  // -------------------------------------------------------------------------
  // Stage 0: counters, shadow registers, window decode
  // -------------------------------------------------------------------------
  logic [HCW-1:0] hcnt_r;
  logic [VCW-1:0] vcnt_r;
  logic [9:0]     sx_r;
  logic [9:0]     sy_r;
  logic [1:0]     ss_r;

  logic           h_last_s;
  logic           v_last_s;

  assign h_last_s = (hcnt_r == HCW'(H_TOTAL - 1));
  assign v_last_s = (vcnt_r == VCW'(V_TOTAL - 1));

  // Pixel and line counters; vcnt advances on the hcnt wrap.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      hcnt_r <= '0;
      vcnt_r <= '0;
    end else if (h_last_s) begin
      hcnt_r <= '0;
      if (v_last_s) begin
        vcnt_r <= '0;
      end else begin
        vcnt_r <= vcnt_r + 1'b1;
      end
    end else begin
      hcnt_r <= hcnt_r + 1'b1;
    end
  end

  // Window shadow registers, reloaded only on the last pixel of a frame.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      sx_r <= 10'd0;
      sy_r <= 10'd0;
      ss_r <= 2'd0;
    end else if (h_last_s && v_last_s) begin
      sx_r <= win_x;
      sy_r <= win_y;
      ss_r <= win_scale;
    end
  end

  logic [31:0]       h_s;
  logic [31:0]       v_s;
  logic [31:0]       x_s;
  logic [31:0]       y_s;
  logic [31:0]       dx_s;
  logic [31:0]       dy_s;
  logic [31:0]       win_w_s;
  logic [31:0]       win_h_s;
  logic [1:0]        shift_s;
  logic              active_s;
  logic              in_win_s;
  logic [ADDR_W-1:0] addr_s;
  logic              hs_s;
  logic              vs_s;
  logic              fs_s;

  // Window decode and image address for the current counter position.
  always_comb begin
    h_s      = 32'(hcnt_r);
    v_s      = 32'(vcnt_r);
    x_s      = 32'(sx_r);
    y_s      = 32'(sy_r);
    // Scale code 3 is not a valid magnification and falls back to 1x.
    shift_s  = (ss_r == 2'd3) ? 2'd0 : ss_r;
    // dx/dy wrap when the counter is left of/above the window; the explicit
    // >= compares below keep such positions out of the window.
    dx_s     = h_s - x_s;
    dy_s     = v_s - y_s;
    win_w_s  = 32'(IMG_W) << shift_s;
    win_h_s  = 32'(IMG_H) << shift_s;
    active_s = (h_s < 32'(H_ACTIVE)) && (v_s < 32'(V_ACTIVE));
    in_win_s = active_s && (h_s >= x_s) && (v_s >= y_s) &&
               (dx_s < win_w_s) && (dy_s < win_h_s);
    addr_s   = ADDR_W'(((dy_s >> shift_s) * 32'(IMG_W)) + (dx_s >> shift_s));
    hs_s     = ((h_s >= 32'(H_ACTIVE + H_FP)) &&
                (h_s <  32'(H_ACTIVE + H_FP + H_SYNC))) ? SYNC_POL : ~SYNC_POL;
    vs_s     = ((v_s >= 32'(V_ACTIVE + V_FP)) &&
                (v_s <  32'(V_ACTIVE + V_FP + V_SYNC))) ? SYNC_POL : ~SYNC_POL;
    fs_s     = (hcnt_r == '0) && (vcnt_r == '0);
  end

`ifdef VGA_BORDER_EN
  logic border_s;

  // Two-pixel frame along every edge of the active area.
  always_comb begin
    border_s = active_s &&
               ((h_s < 32'd2) || (h_s > 32'(H_ACTIVE - 3)) ||
                (v_s < 32'd2) || (v_s > 32'(V_ACTIVE - 3)));
  end
`endif

  // -------------------------------------------------------------------------
  // Stage 1: memory request plus timing flags
  // -------------------------------------------------------------------------
  logic              mem_rd_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic              act1_r;
  logic              hs1_r;
  logic              vs1_r;
  logic              fs1_r;

  // Memory request; the address holds its last value between reads.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      mem_rd_r   <= 1'b0;
      mem_addr_r <= '0;
      act1_r     <= 1'b0;
      hs1_r      <= ~SYNC_POL;
      vs1_r      <= ~SYNC_POL;
      fs1_r      <= 1'b0;
    end else begin
      mem_rd_r   <= in_win_s;
      if (in_win_s) begin
        mem_addr_r <= addr_s;
      end
      act1_r     <= active_s;
      hs1_r      <= hs_s;
      vs1_r      <= vs_s;
      fs1_r      <= fs_s;
    end
  end

  assign mem.mem_rd   = mem_rd_r;
  assign mem.mem_addr = mem_addr_r;

  // -------------------------------------------------------------------------
  // Stage 2: flags aligned with the memory read latency
  // -------------------------------------------------------------------------
  logic win2_r;
  logic act2_r;
  logic hs2_r;
  logic vs2_r;
  logic fs2_r;

  // Delay timing flags while the memory produces pix_data.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      win2_r <= 1'b0;
      act2_r <= 1'b0;
      hs2_r  <= ~SYNC_POL;
      vs2_r  <= ~SYNC_POL;
      fs2_r  <= 1'b0;
    end else begin
      win2_r <= mem_rd_r;
      act2_r <= act1_r;
      hs2_r  <= hs1_r;
      vs2_r  <= vs1_r;
      fs2_r  <= fs1_r;
    end
  end

`ifdef VGA_BORDER_EN
  logic border1_r;
  logic border2_r;

  // Border flag follows the same two-stage delay as the other flags.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      border1_r <= 1'b0;
      border2_r <= 1'b0;
    end else begin
      border1_r <= border_s;
      border2_r <= border1_r;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Stage 3: colour select and output registers
  // -------------------------------------------------------------------------
  logic [CW-1:0] r_s;
  logic [CW-1:0] g_s;
  logic [CW-1:0] b_s;
  logic [11:0]   rgb_s;

  assign r_s = mem.pix_data[CW-1:0];
  assign g_s = mem.pix_data[2*CW-1:CW];
  assign b_s = mem.pix_data[3*CW-1:2*CW];

  // Colour priority: blanking, then border (if built), image, background.
  always_comb begin
    rgb_s = 12'h000;
    if (!act2_r) begin
      rgb_s = 12'h000;
    end
`ifdef VGA_BORDER_EN
    else if (border2_r) begin
      rgb_s = BORDER_COLOR;
    end
`endif
    else if (win2_r) begin
      rgb_s = {expand_chan(r_s), expand_chan(g_s), expand_chan(b_s)};
    end else begin
      rgb_s = BG_COLOR;
    end
  end

  // Output registers.
  always_ff @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) begin
      vga_rgb     <= 12'h000;
      vga_hsync   <= ~SYNC_POL;
      vga_vsync   <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      vga_rgb     <= rgb_s;
      vga_hsync   <= hs2_r;
      vga_vsync   <= vs2_r;
      frame_start <= fs2_r;
    end
  end

endmodule

// File: tb/tb_vga_window_ctrl.sv
`timescale 1ns/1ps
module tb_vga_window_ctrl;

  // Reduced timing so several whole frames fit in a short run.
  localparam int HA = 48, HFP = 4, HSW = 8, HBP = 4, HT = HA + HFP + HSW + HBP;
  localparam int VA = 24, VFP = 2, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int IW = 16, IH = 8, AW = 7, CWB = 2;
  localparam logic [11:0] BG = 12'h123;

  logic        clk25M = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  win_x = 10'd0;
  logic [9:0]  win_y = 10'd0;
  logic [1:0]  win_scale = 2'd0;
  logic [9:0]  zero10 = 10'd0;
  logic [1:0]  zero2 = 2'd0;
  logic        hs, vs, fs;
  logic [11:0] rgb;
  logic        hs_d, vs_d, fs_d;
  logic [11:0] rgb_d;

  int n_assert = 0;
  int n_fail = 0;
  int ecount;

  vga_window_ctrl_if #(.ADDR_W(AW), .CW(CWB)) mem_s ();
  vga_window_ctrl_if #(.ADDR_W(15), .CW(2))   mem_d ();

  always #20 clk25M = ~clk25M;

  vga_window_ctrl #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .IMG_W(IW), .IMG_H(IH), .ADDR_W(AW), .CW(CWB),
    .SYNC_POL(1'b0), .BG_COLOR(BG), .BORDER_COLOR(12'hF00)
  ) dut (
    .clk25M(clk25M), .reset_n(reset_n),
    .win_x(win_x), .win_y(win_y), .win_scale(win_scale),
    .mem(mem_s.master),
    .vga_hsync(hs), .vga_vsync(vs), .vga_rgb(rgb), .frame_start(fs)
  );

  // Default-parameter instance, used for the full-size line timing.
  vga_window_ctrl dut_def (
    .clk25M(clk25M), .reset_n(reset_n),
    .win_x(zero10), .win_y(zero10), .win_scale(zero2),
    .mem(mem_d.master),
    .vga_hsync(hs_d), .vga_vsync(vs_d), .vga_rgb(rgb_d), .frame_start(fs_d)
  );

  assign mem_d.pix_data = 6'h00;

  function automatic logic [5:0] rom(input int a);
    return 6'(a * 37 + 27);
  endfunction

  // Synchronous image memory: data one clock after the read strobe.
  always @(posedge clk25M) begin
    if (mem_s.mem_rd) mem_s.pix_data <= rom(int'(mem_s.mem_addr));
  end

  // Clocks since the last reset release.
  always @(posedge clk25M or negedge reset_n) begin
    if (!reset_n) ecount <= 0;
    else          ecount <= ecount + 1;
  end

  typedef struct { int cyc; int x; int y; int s; } set_t;
  set_t log_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h, expected %0h (clock %0d)", name, act, exp, ecount);
    end
  endtask

  task automatic log_inputs();
    set_t e;
    e.cyc = ecount; e.x = int'(win_x); e.y = int'(win_y); e.s = int'(win_scale);
    log_q.push_back(e);
  endtask

  task automatic set_win(input int x, input int y, input int s);
    win_x = 10'(x); win_y = 10'(y); win_scale = 2'(s);
    log_inputs();
  endtask

  // Expected behaviour of counter position c (cycles since release).
  task automatic model(input int c, output int mrd, output int maddr,
                       output int ergb, output int ehs, output int evs, output int efs);
    int h, v, f, x, y, s, ww, wh, act, bord, pix;
    mrd = 0; maddr = 0; ergb = 0; ehs = 1; evs = 1; efs = 0;
    if (c >= 0) begin
      h = c % HT; v = (c / HT) % VT; f = c / FT;
      x = 0; y = 0; s = 0;
      if (f > 0)
        foreach (log_q[i])
          if (log_q[i].cyc <= f * FT - 1) begin
            x = log_q[i].x; y = log_q[i].y; s = log_q[i].s;
          end
      if (s == 3) s = 0;
      ww = IW * (1 << s); wh = IH * (1 << s);
      act = (h < HA && v < VA) ? 1 : 0;
      mrd = (act == 1 && h >= x && v >= y && h - x < ww && v - y < wh) ? 1 : 0;
      bord = 0;
`ifdef VGA_BORDER_EN
      bord = (act == 1 && (h < 2 || h >= HA - 2 || v < 2 || v >= VA - 2)) ? 1 : 0;
`endif
      if (act == 0) ergb = 0;
      else if (bord == 1) ergb = 'hF00;
      else if (mrd == 1) begin
        maddr = (((v - y) / (1 << s)) * IW + (h - x) / (1 << s)) % (1 << AW);
        pix = int'(rom(maddr));
        ergb = (((pix % 4) * 5) << 8) | ((((pix / 4) % 4) * 5) << 4) | ((pix / 16) * 5);
      end else ergb = int'(BG);
      if (mrd == 1) maddr = (((v - y) / (1 << s)) * IW + (h - x) / (1 << s)) % (1 << AW);
      ehs = (h >= HA + HFP && h < HA + HFP + HSW) ? 0 : 1;
      evs = (v >= VA + VFP && v < VA + VFP + VSW) ? 0 : 1;
      efs = (h == 0 && v == 0) ? 1 : 0;
    end
  endtask

  // Per-clock comparison of every output against the model.
  initial begin
    int e, mrd, maddr, ergb, ehs, evs, efs, last_addr;
    last_addr = 0;
    forever begin
      @(negedge clk25M);
      e = ecount;
      if (!reset_n) last_addr = 0;
      model(e - 1, mrd, maddr, ergb, ehs, evs, efs);
      if (mrd == 1) last_addr = maddr;
      check("mem_rd", int'(mem_s.mem_rd), mrd);
      check("mem_addr", int'(mem_s.mem_addr), last_addr);
      model(e - 3, mrd, maddr, ergb, ehs, evs, efs);
      check("vga_rgb", int'(rgb), ergb);
      check("vga_hsync", int'(hs), ehs);
      check("vga_vsync", int'(vs), evs);
      check("frame_start", int'(fs), efs);
    end
  end

  task automatic wait_until(input int n);
    int guard;
    guard = 0;
    while (ecount != n && guard < 30000) begin
      @(negedge clk25M);
      guard++;
    end
    if (ecount != n) check("wait_bound", ecount, n);
  endtask

  // Directed stimulus with hand-computed spot checks.
  initial begin
    win_x = 10'd8; win_y = 10'd4; win_scale = 2'd0;
    repeat (3) @(negedge clk25M);
    check("rst_rgb", int'(rgb), 0);
    check("rst_hsync", int'(hs), 1);
    check("rst_mem_rd", int'(mem_s.mem_rd), 0);
    #1 reset_n = 1'b1;
    log_q.delete();
    log_inputs();

    wait_until(2);    check("lit_fs_early", int'(fs), 0);
    wait_until(3);    check("lit_fs_first", int'(fs), 1);
                      check("lit_fs_def", int'(fs_d), 1);
`ifdef VGA_BORDER_EN
                      check("lit_px00", int'(rgb), 'hF00);
                      check("lit_px00_def", int'(rgb_d), 'hF00);
`else
                      check("lit_px00", int'(rgb), 'hFA5);
                      check("lit_px00_def", int'(rgb_d), 'h000);
`endif
    wait_until(133);  check("lit_px22", int'(rgb), 'h550);
    wait_until(658);  check("lit_hs658", int'(hs_d), 1);
                      check("lit_vs_def", int'(vs_d), 1);
    wait_until(659);  check("lit_hs659", int'(hs_d), 0);
    wait_until(754);  check("lit_hs754", int'(hs_d), 0);
    wait_until(755);  check("lit_hs755", int'(hs_d), 1);
    wait_until(1459); check("lit_hs1459", int'(hs_d), 0);
    wait_until(1666); check("lit_vs1666", int'(vs), 1);
    wait_until(1667); check("lit_vs1667", int'(vs), 0);
    wait_until(1794); check("lit_vs1794", int'(vs), 0);
    wait_until(1795); check("lit_vs1795", int'(vs), 1);

    // Frame 1: window at (8,4), 1x.
    wait_until(2185); check("lit_rd_8_4", int'(mem_s.mem_rd), 1);
                      check("lit_addr_8_4", int'(mem_s.mem_addr), 0);
    wait_until(2187); check("lit_rgb_8_4", int'(rgb), 'hFA5);
    wait_until(2200); check("lit_addr_23_4", int'(mem_s.mem_addr), 15);
    wait_until(2201); check("lit_rd_24_4", int'(mem_s.mem_rd), 0);
                      check("lit_hold_24_4", int'(mem_s.mem_addr), 15);
    wait_until(2203); check("lit_bg_24_4", int'(rgb), int'(BG));

    // Frame 2: origin, 2x.
    wait_until(2500); #1 set_win(0, 0, 1);
    wait_until(3843); check("lit_addr_2_0", int'(mem_s.mem_addr), 1);
    wait_until(3872); check("lit_rd_31_0", int'(mem_s.mem_rd), 1);
                      check("lit_addr_31_0", int'(mem_s.mem_addr), 15);
    wait_until(3873); check("lit_rd_32_0", int'(mem_s.mem_rd), 0);
    wait_until(3906); check("lit_addr_1_1", int'(mem_s.mem_addr), 0);
    wait_until(3969); check("lit_addr_0_2", int'(mem_s.mem_addr), 16);

    // Mid-frame change at line 10 must wait for the next frame.
    wait_until(4480); #1 set_win(20, 0, 1);
    wait_until(4609); check("lit_rd_0_12", int'(mem_s.mem_rd), 1);
                      check("lit_addr_0_12", int'(mem_s.mem_addr), 96);
    wait_until(5761); check("lit_rd_f3_0_0", int'(mem_s.mem_rd), 0);
    wait_until(5781); check("lit_rd_f3_20_0", int'(mem_s.mem_rd), 1);
                      check("lit_addr_f3_20_0", int'(mem_s.mem_addr), 0);

    // Frame 4: window clipped at the right edge.
    wait_until(6000); #1 set_win(40, 0, 0);
    wait_until(7720); check("lit_rd_39_0", int'(mem_s.mem_rd), 0);
    wait_until(7728); check("lit_rd_47_0", int'(mem_s.mem_rd), 1);
                      check("lit_addr_47_0", int'(mem_s.mem_addr), 7);
    wait_until(7729); check("lit_rd_48_0", int'(mem_s.mem_rd), 0);

    // Frame 5: 4x; frame 6: scale code 3 behaves as 1x.
    wait_until(8000);  #1 set_win(4, 2, 2);
    wait_until(9803);  check("lit_addr_4x", int'(mem_s.mem_addr), 1);
    wait_until(10000); #1 set_win(3, 1, 3);
    wait_until(11589); check("lit_rd_s3", int'(mem_s.mem_rd), 1);
                       check("lit_addr_s3", int'(mem_s.mem_addr), 1);

    // Reset in the middle of frame 6.
    wait_until(12200);
    #5 reset_n = 1'b0;
    repeat (4) @(negedge clk25M);
    check("mid_rst_rgb", int'(rgb), 0);
    check("mid_rst_fs", int'(fs), 0);
    check("mid_rst_addr", int'(mem_s.mem_addr), 0);
    #1 reset_n = 1'b1;
    log_q.delete();
    log_inputs();
    wait_until(3);          check("lit_fs_after_rst", int'(fs), 1);
    wait_until(2 * FT + 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
